// File: rtl/pulse_handshake_tx.sv
// Source-side launcher of a two-phase toggle handshake: one req_tgl transition
// per accepted event, with a saturating queue of events awaiting launch.
module pulse_handshake_tx #(
    parameter int CNT_W = 4
) (
    input  logic             clk_fast,
    input  logic             rst_n,
    input  logic             din_en,
    input  logic             ack_tgl,
    input  logic             ovf_clr,
    output logic             req_tgl,
    output logic             busy,
    output logic [CNT_W-1:0] pend_cnt,
    output logic             overflow
);

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t             state;
    state_t             state_nxt;
    logic               ack_s1;
    logic               ack_s2;
    logic               req_nxt;
    logic               busy_nxt;
    logic               ovf_nxt;
    logic               drop;
    logic [CNT_W-1:0]   pend_nxt;

    // Two-flop synchronizer; ack_tgl is asynchronous to clk_fast.
    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            ack_s1 <= 1'b0;
            ack_s2 <= 1'b0;
        end else begin
            ack_s1 <= ack_tgl;
            ack_s2 <= ack_s1;
        end
    end

    // Next-state, launch and queue bookkeeping.
    always_comb begin
        state_nxt = state;
        req_nxt   = req_tgl;
        pend_nxt  = pend_cnt;
        drop      = 1'b0;
        case (state)
            IDLE: begin
                // A queued event goes first; a same-edge strobe takes its slot in the queue.
                if (din_en || (pend_cnt != CNT_ZERO)) begin
                    req_nxt   = ~req_tgl;
                    state_nxt = WAIT_ACK;
                    if ((pend_cnt != CNT_ZERO) && !din_en) begin
                        pend_nxt = pend_cnt - CNT_ONE;
                    end else begin
                        pend_nxt = pend_cnt;
                    end
                end else begin
                    state_nxt = IDLE;
                end
            end
            WAIT_ACK: begin
                if (din_en) begin
                    if (pend_cnt == CNT_MAX) begin
                        drop = 1'b1;
                    end else begin
                        pend_nxt = pend_cnt + CNT_ONE;
                    end
                end else begin
                    pend_nxt = pend_cnt;
                end
                if (ack_s2 == req_tgl) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = WAIT_ACK;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (drop) begin
            ovf_nxt = 1'b1;
        end else if (ovf_clr) begin
            ovf_nxt = 1'b0;
        end else begin
            ovf_nxt = overflow;
        end
        busy_nxt = (state_nxt == WAIT_ACK);
    end

    // State and registered outputs.
    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            req_tgl  <= 1'b0;
            busy     <= 1'b0;
            pend_cnt <= CNT_ZERO;
            overflow <= 1'b0;
        end else begin
            state    <= state_nxt;
            req_tgl  <= req_nxt;
            busy     <= busy_nxt;
            pend_cnt <= pend_nxt;
            overflow <= ovf_nxt;
        end
    end

endmodule

// File: doc/pulse_handshake_tx.md
PULSE_HANDSHAKE_TX -- requirements
Module: pulse_handshake_tx

Interface
REQ-001 SHALL have parameter CNT_W, default 4, the width of the pending-event counter (queue depth 2^CNT_W-1).
REQ-002 SHALL have port clk_fast  input  1  the single clock; all state on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert and active-low.
REQ-004 SHALL have port din_en  input  1  event strobe; each cycle sampled high is one event.
REQ-005 SHALL have port ack_tgl  input  1  acknowledge toggle from the receiving domain, asynchronous to clk_fast.
REQ-006 SHALL have port ovf_clr  input  1  synchronous clear of overflow.
REQ-007 SHALL have port req_tgl  output  1  request toggle; one transition per launched event.
REQ-008 SHALL have port busy  output  1  high while a launched request awaits acknowledge.
REQ-009 SHALL have port pend_cnt  output  CNT_W  events accepted but not yet launched.
REQ-010 SHALL have port overflow  output  1  sticky; an event was dropped.

Function
REQ-011 SHALL be the source-side launcher of a two-phase toggle handshake; the far end synchronizes req_tgl, emits one pulse per transition, and returns ack_tgl equal to its synchronized copy of req_tgl.
REQ-012 SHALL pass ack_tgl through a two-flop synchronizer (ack_s1, ack_s2) before any use; no other logic reads ack_tgl.
REQ-013 SHALL implement FSM states IDLE and WAIT_ACK; busy SHALL be 1 exactly when state is WAIT_ACK.
REQ-014 SHALL, in IDLE with din_en=1 or pend_cnt>0, invert req_tgl and enter WAIT_ACK on the same edge; all outputs registered, so req_tgl and busy change one edge after the sampled din_en.
REQ-015 SHALL, in IDLE with din_en=1 and pend_cnt=0, launch the event directly; pend_cnt stays 0.
REQ-016 SHALL, in IDLE with pend_cnt>0, launch one queued event and decrement pend_cnt; a simultaneous din_en=1 is queued, so pend_cnt is unchanged that edge.
REQ-017 SHALL, in WAIT_ACK, increment pend_cnt on each edge where din_en=1.
REQ-018 SHALL, when an increment would exceed 2^CNT_W-1, hold pend_cnt at max, drop the event and set overflow to 1; no wrap-around.
REQ-019 SHALL leave WAIT_ACK for IDLE on the edge where ack_s2 equals req_tgl; ack_tgl changing before edge E1 yields busy=0 after edge E3.
REQ-020 SHALL spend at least one cycle in IDLE between launches, so back-to-back launches are separated by ack round trip plus one cycle.
REQ-021 SHALL ignore ack_s2 in IDLE; a spurious ack transition SHALL NOT change state, req_tgl or pend_cnt.
REQ-022 SHALL clear overflow on an edge with ovf_clr=1; if a drop occurs on the same edge, set wins and overflow stays 1.
REQ-023 SHALL produce exactly one req_tgl transition per accepted event, never more, in all input sequences.

Reset
REQ-024 SHALL, on rst_n=0, immediately force state=IDLE, req_tgl=0, ack_s1=ack_s2=0, pend_cnt=0, busy=0 and overflow=0 without waiting for a clock edge.
REQ-025 SHALL discard the outstanding request and all queued events on reset mid-operation; the receiving domain is reset by the same rst_n.
REQ-026 SHALL resume normal operation on the first rising edge after rst_n deasserts.

Verification
REQ-027 Single event: din_en=1 for one cycle, ack_tgl looped back after 3 cycles -> req_tgl 0->1 after 1 edge, busy=1, busy=0 three edges after ack_tgl rises, pend_cnt=0 throughout.
REQ-028 Burst: din_en=1 for 5 consecutive cycles, ack delay 4 -> pend_cnt peaks at 4, exactly 5 req_tgl transitions, final req_tgl=1, overflow=0.
REQ-029 Overflow (CNT_W=2): din_en=1 for 6 cycles, ack held -> pend_cnt saturates at 3, overflow=1, after acks exactly 4 transitions; ovf_clr=1 then clears overflow.
REQ-030 Simultaneous: in IDLE with pend_cnt=2 and din_en=1 -> launch occurs, pend_cnt stays 2.
REQ-031 Reset mid-operation: rst_n=0 while busy=1 and pend_cnt=3 -> all outputs 0 before the next edge, no further transitions after release.
REQ-032 Spurious ack: toggle ack_tgl in IDLE -> state, req_tgl and pend_cnt unchanged.
